// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_store_buffer
//  Description : Data-memory responder between EX and a single-port DMEM
//                SRAM. Stores post into an in-order circular store buffer
//                that drains to SRAM in idle slots; loads take SRAM priority
//                and return data one cycle later, with store-to-load
//                forwarding (youngest matching entry wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int SB_DEPTH        = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [DMEM_WORD_WIDTH-1:0] in_sram_rdata,
    output logic                       out_sram_en,
    output logic                       out_sram_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_sram_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_sram_wdata,
    output logic                       out_load_valid,
    output logic [DMEM_WORD_WIDTH-1:0] out_load_word,
    output logic                       out_stall,
    output logic                       out_sb_empty
);

    // Pointers wrap naturally because SB_DEPTH is a power of two; the count
    // needs one extra bit to represent a full buffer.
    localparam int                 c_PTR_W = $clog2(SB_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(SB_DEPTH);

    // Buffer storage and bookkeeping
    logic [DMEM_ADDR_WIDTH-1:0] r_sb_addr [SB_DEPTH];
    logic [DMEM_WORD_WIDTH-1:0] r_sb_data [SB_DEPTH];
    logic [SB_DEPTH-1:0]        r_sb_valid;
    logic [c_PTR_W-1:0]         r_head;
    logic [c_PTR_W-1:0]         r_tail;
    logic [c_CNT_W-1:0]         r_count;

    // Load return pipeline
    logic                       r_load_valid;
    logic                       r_fwd_hit;
    logic [DMEM_WORD_WIDTH-1:0] r_fwd_word;

    // Combinational control
    logic                       w_full;
    logic                       w_stall;
    logic                       w_load_acc;
    logic                       w_store_acc;
    logic                       w_fwd_match;
    logic [DMEM_WORD_WIDTH-1:0] w_fwd_word;
    logic                       w_hit;
    logic                       w_sram_rd;
    logic                       w_drain;

    // A full buffer refuses any request; the drain slot frees an entry the
    // same cycle, so the stall never lasts more than one cycle.
    assign w_full      = (r_count == c_FULL);
    assign w_stall     = w_full & (in_act_load_dmem | in_act_store_dmem);
    assign w_load_acc  = in_act_load_dmem  & ~w_stall;
    assign w_store_acc = in_act_store_dmem & ~w_stall;

    // Forwarding search in age order from the head; later (younger) matches
    // override earlier ones. The entry draining this cycle is still valid.
    always_comb begin
        w_fwd_match = 1'b0;
        w_fwd_word  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (r_sb_valid[r_head + c_PTR_W'(i)] &&
                (r_sb_addr[r_head + c_PTR_W'(i)] == in_dmem_rd_addr)) begin
                w_fwd_match = 1'b1;
                w_fwd_word  = r_sb_data[r_head + c_PTR_W'(i)];
            end
        end
    end

    assign w_hit     = w_load_acc & w_fwd_match;
    // SRAM slot arbitration: a load that must read SRAM wins, else drain head.
    assign w_sram_rd = w_load_acc & ~w_fwd_match;
    assign w_drain   = ~w_sram_rd & (r_count != '0);

    assign out_sram_en    = w_sram_rd | w_drain;
    assign out_sram_we    = w_drain;
    assign out_sram_addr  = w_sram_rd ? in_dmem_rd_addr :
                            w_drain   ? r_sb_addr[r_head] : '0;
    assign out_sram_wdata = w_drain   ? r_sb_data[r_head] : '0;

    assign out_stall      = w_stall;
    assign out_sb_empty   = (r_count == '0);
    assign out_load_valid = r_load_valid;
    assign out_load_word  = !r_load_valid ? '0 :
                            r_fwd_hit     ? r_fwd_word : in_sram_rdata;

    // Pointer, count, valid-bit and load-return state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_sb_valid   <= '0;
            r_load_valid <= 1'b0;
            r_fwd_hit    <= 1'b0;
            r_fwd_word   <= '0;
        end else begin
            if (w_drain) begin
                r_head             <= r_head + c_PTR_W'(1);
                r_sb_valid[r_head] <= 1'b0;
            end
            // Head and tail only coincide when empty (no drain) or full
            // (store stalled), so these two valid updates never collide.
            if (w_store_acc) begin
                r_tail             <= r_tail + c_PTR_W'(1);
                r_sb_valid[r_tail] <= 1'b1;
            end
            case ({w_store_acc, w_drain})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_load_valid <= w_load_acc;
            r_fwd_hit    <= w_hit;
            r_fwd_word   <= w_hit ? w_fwd_word : '0;
        end
    end

    // Entry payload capture; contents are qualified by the valid bits so no
    // reset is needed here.
    always_ff @(posedge clock) begin
        if (w_store_acc) begin
            r_sb_addr[r_tail] <= in_dmem_wr_addr;
            r_sb_data[r_tail] <= in_dmem_wr_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_store_buffer
//  Description : Scoreboard bench for dmem_store_buffer. The driver pushes
//                expected SRAM writes and load returns into queues; a monitor
//                on the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_store_buffer;

    localparam int AW = 12;
    localparam int DW = 16;

    typedef struct {
        int            cyc;
        logic [DW-1:0] word;
    } ld_exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ld = 1'b0;
    logic          st = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_word = '0;
    logic [DW-1:0] sram_rdata = '0;

    logic          o_en;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic          o_valid;
    logic [DW-1:0] o_word;
    logic          o_stall;
    logic          o_empty;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          allow_dual = 1'b0;

    logic [AW+DW-1:0] wq[$];
    ld_exp_t          lq[$];

    dmem_store_buffer #(
        .DMEM_ADDR_WIDTH (AW),
        .DMEM_WORD_WIDTH (DW),
        .SB_DEPTH        (4)
    ) u_dut (
        .clock             (clock),
        .reset             (reset),
        .in_act_load_dmem  (ld),
        .in_act_store_dmem (st),
        .in_dmem_rd_addr   (rd_addr),
        .in_dmem_wr_addr   (wr_addr),
        .in_dmem_wr_word   (wr_word),
        .in_sram_rdata     (sram_rdata),
        .out_sram_en       (o_en),
        .out_sram_we       (o_we),
        .out_sram_addr     (o_addr),
        .out_sram_wdata    (o_wdata),
        .out_load_valid    (o_valid),
        .out_load_word     (o_word),
        .out_stall         (o_stall),
        .out_sb_empty      (o_empty)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Preloaded SRAM contents seen by reads
    function automatic logic [DW-1:0] sram_init(input logic [AW-1:0] a);
        case (a)
            12'h030: return 16'h5A5A;
            12'h100: return 16'h1234;
            default: return 16'hDEAD;
        endcase
    endfunction

    // SRAM read model: data one cycle after a read enable
    always @(posedge clock) begin
        if (o_en && !o_we) sram_rdata <= sram_init(o_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // EX never issues a load and a store together; the fill/reset scenarios
    // deliberately do so because one-slot-per-cycle draining otherwise keeps
    // the buffer from ever holding more than one entry.
    always @(negedge clock) begin
        if (!reset && !allow_dual)
            assert (!(ld && st)) else $error("FAIL protocol load+store same cycle");
    end

    // Monitor: pops and compares whenever the DUT writes SRAM or returns data
    always @(negedge clock) begin
        logic [AW+DW-1:0] we_exp;
        ld_exp_t          le;
        if (!reset) begin
            if (o_en && o_we) begin
                chk("write_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    we_exp = wq.pop_front();
                    chk("sram_waddr", 32'(o_addr), 32'(we_exp[AW+DW-1:DW]));
                    chk("sram_wdata", 32'(o_wdata), 32'(we_exp[DW-1:0]));
                end
            end
            if (o_valid) begin
                chk("load_expected", 32'(lq.size() != 0), 32'd1);
                if (lq.size() != 0) begin
                    le = lq.pop_front();
                    chk("load_cycle", 32'(cyc), 32'(le.cyc));
                    chk("load_word", 32'(o_word), 32'(le.word));
                end
            end else begin
                chk("idle_word_zero", 32'(o_word), 32'd0);
            end
        end
    end

    // One request cycle: drive after the edge, check stall, record expectations
    task automatic drive(input logic l, input logic s, input logic [AW-1:0] ra,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_ld, input logic exp_stall);
        @(posedge clock);
        #1;
        ld = l; st = s; rd_addr = ra; wr_addr = wa; wr_word = wd;
        #1;
        chk("stall", 32'(o_stall), 32'(exp_stall));
        if (!exp_stall) begin
            if (s) wq.push_back({wa, wd});
            if (l) lq.push_back('{cyc + 1, exp_ld});
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_en_we", 32'({o_en, o_we}), 32'd0);
        chk("rst_addr_wdata", 32'({o_addr, o_wdata}), 32'd0);
        chk("rst_valid_word", 32'({o_valid, o_word}), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single store drains in the following idle cycle
        drive(1'b0, 1'b1, '0, 12'h010, 16'hBEEF, '0, 1'b0);
        idle();
        chk("store_pending_not_empty", 32'(o_empty), 32'd0);
        idle();
        chk("store_drained_empty", 32'(o_empty), 32'd1);

        // Same-address stores, youngest forwarded, hit does not read SRAM
        allow_dual = 1'b1;
        drive(1'b1, 1'b1, 12'h100, 12'h020, 16'h1111, 16'h1234, 1'b0);
        drive(1'b1, 1'b1, 12'h100, 12'h020, 16'h2222, 16'h1234, 1'b0);
        drive(1'b1, 1'b0, 12'h020, '0, '0, 16'h2222, 1'b0);
        allow_dual = 1'b0;
        chk("hit_slot_is_drain", 32'({o_en, o_we}), 32'h3);
        chk("hit_drain_addr", 32'(o_addr), 32'h020);
        idle();
        idle();
        chk("fwd_drained_empty", 32'(o_empty), 32'd1);

        // Plain SRAM load
        drive(1'b1, 1'b0, 12'h030, '0, '0, 16'h5A5A, 1'b0);
        chk("miss_read_slot", 32'({o_en, o_we, o_addr}), 32'({2'b10, 12'h030}));
        idle();
        idle();

        // Fill to full, one-cycle stall drains the head, then accept
        allow_dual = 1'b1;
        drive(1'b1, 1'b1, 12'h100, 12'h200, 16'hA000, 16'h1234, 1'b0);
        drive(1'b1, 1'b1, 12'h100, 12'h201, 16'hA001, 16'h1234, 1'b0);
        drive(1'b1, 1'b1, 12'h100, 12'h200, 16'hA002, 16'h1234, 1'b0);
        drive(1'b1, 1'b1, 12'h100, 12'h203, 16'hA003, 16'h1234, 1'b0);
        drive(1'b0, 1'b1, '0, 12'h204, 16'hA004, '0, 1'b1);
        allow_dual = 1'b0;
        chk("stall_drains_head", 32'({o_en, o_we, o_addr}), 32'({2'b11, 12'h200}));
        drive(1'b0, 1'b1, '0, 12'h204, 16'hA004, '0, 1'b0);
        repeat (4) idle();
        chk("fill_drained_empty", 32'(o_empty), 32'd1);

        // Store burst without loads never stalls; writes in issue order
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, '0, 12'(12'h300 + i), 16'(16'hB000 + i), '0, 1'b0);
        idle();
        idle();
        chk("burst_drained_empty", 32'(o_empty), 32'd1);

        // Reset with three entries buffered and a load in flight
        allow_dual = 1'b1;
        drive(1'b1, 1'b1, 12'h100, 12'h400, 16'hC000, 16'h1234, 1'b0);
        drive(1'b1, 1'b1, 12'h100, 12'h401, 16'hC001, 16'h1234, 1'b0);
        drive(1'b1, 1'b1, 12'h100, 12'h402, 16'hC002, 16'h1234, 1'b0);
        @(posedge clock);
        #1;
        ld = 1'b0; st = 1'b0; allow_dual = 1'b0;
        reset = 1'b1;
        wq.delete();
        lq.delete();
        #1;
        chk("midrst_empty", 32'(o_empty), 32'd1);
        chk("midrst_en", 32'(o_en), 32'd0);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("postrst_empty", 32'(o_empty), 32'd1);
        chk("postrst_en", 32'(o_en), 32'd0);
        chk("postrst_valid", 32'(o_valid), 32'd0);
        idle();
        idle();

        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("loads_outstanding", 32'(lq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
